// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus launch sequencer feeding a UART transmitter.
// Define UART_TX_BUF_GAP_EN to insert GAP_CLKS idle clocks after every frame.
module uart_tx_buffer #(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] GAP_CLKS = 16'd0
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Wr_DV,
  input  logic [7:0]                 i_Wr_Byte,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic                       o_Overflow,
  input  logic                       i_Ovf_Clr,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic                       o_Busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACT, S_WAIT_DONE, S_WAIT_REL
`ifdef UART_TX_BUF_GAP_EN
    , S_GAP
`endif
  } state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic push, pop;
`ifdef UART_TX_BUF_GAP_EN
  logic [15:0] gap_q, gap_d;
`else
  logic unused_gap;
  assign unused_gap = ^GAP_CLKS;
`endif
  // Flags use the registered full so a pop never makes room for a same-cycle write.
  assign push = i_Wr_DV && !full_q;
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
`ifdef UART_TX_BUF_GAP_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      S_IDLE: if (!empty_q && !i_Tx_Active && !i_Tx_Done) begin
        pop       = 1'b1;
        tx_dv_d   = 1'b1;
        tx_byte_d = mem_q[rd_ptr_q];
        state_d   = S_WAIT_ACT;
      end
      S_WAIT_ACT:  state_d = i_Tx_Active ? S_WAIT_DONE : S_WAIT_ACT;
      S_WAIT_DONE: state_d = i_Tx_Done ? S_WAIT_REL : S_WAIT_DONE;
`ifdef UART_TX_BUF_GAP_EN
      S_WAIT_REL: if (!i_Tx_Done) begin
        state_d = (GAP_CLKS != 16'd0) ? S_GAP : S_IDLE;
        gap_d   = GAP_CLKS - 16'd1;
      end
      S_GAP: begin
        state_d = (gap_q == 16'd0) ? S_IDLE : S_GAP;
        gap_d   = (gap_q == 16'd0) ? gap_q : gap_q - 16'd1;
      end
`else
      S_WAIT_REL: state_d = i_Tx_Done ? S_WAIT_REL : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = count_d == CW'(DEPTH);
    empty_d  = count_d == '0;
    ovf_d    = (i_Wr_DV && full_q) ? 1'b1 : i_Ovf_Clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
`ifdef UART_TX_BUF_GAP_EN
      gap_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
`ifdef UART_TX_BUF_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end
  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = (state_q != S_IDLE) || !empty_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: scoreboard bench with a behavioural 4-clocks-per-bit transmitter.
// Build with UART_TX_BUF_GAP_EN to exercise the inter-frame gap (GAP_CLKS=10).
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;
`ifdef UART_TX_BUF_GAP_EN
  localparam int GAP = 10;
`else
  localparam int GAP = 0;
`endif
  logic clk, rst_n, wr_dv, ovf_clr, tx_active, tx_done, stall;
  logic [7:0] wr_byte;
  logic o_Full, o_Empty, o_Overflow, o_Tx_DV, o_Busy;
  logic [$clog2(DEPTH+1)-1:0] o_Count;
  logic [7:0] o_Tx_Byte;
  logic act_in;
  assign act_in = tx_active | stall;

  uart_tx_buffer #(.DEPTH(DEPTH), .GAP_CLKS(16'(GAP))) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
    .i_Ovf_Clr(ovf_clr), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(act_in), .i_Tx_Done(tx_done), .o_Busy(o_Busy)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: queue of accepted bytes, occupancy, sticky overflow.
  logic [7:0] expq[$];
  int mcnt = 0, cyc = 0, fall_cyc = 0, rel_cyc = 0, launches = 0, tx_cnt = 0;
  logic movf = 0, seq_owned = 0, qaf = 0, tx_busy = 0, acc;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      mcnt = 0; movf = 0; seq_owned = 0; rel_cyc = 0; qaf = 0;
      chk("rst_dv", o_Tx_DV, 0);
      chk("rst_byte", o_Tx_Byte, 0);
      chk("rst_count", o_Count, 0);
      chk("rst_empty", o_Empty, 1);
      chk("rst_full", o_Full, 0);
      chk("rst_ovf", o_Overflow, 0);
      chk("rst_busy", o_Busy, 0);
    end else begin
      acc = wr_dv && mcnt < DEPTH;
      if (wr_dv && mcnt == DEPTH) movf = 1;
      else if (ovf_clr) movf = 0;
      if (o_Tx_DV) begin
        launches++;
        last_byte = o_Tx_Byte;
        chk("dv_while_tx_busy", tx_busy || stall, 0);
        chk("dv_with_fifo_empty", expq.size() == 0, 0);
        if (expq.size() != 0) begin
          chk("tx_byte_order", o_Tx_Byte, expq.pop_front());
          mcnt--;
        end
        if (qaf) chk("relaunch_delay", cyc - fall_cyc, GAP + 2);
        qaf = 0;
        seq_owned = 1;
      end
      if (acc) begin expq.push_back(wr_byte); mcnt++; end
      chk("count", o_Count, mcnt);
      chk("empty", o_Empty, mcnt == 0);
      chk("full", o_Full, mcnt == DEPTH);
      chk("overflow", o_Overflow, movf);
      chk("busy", o_Busy, mcnt > 0 || seq_owned || cyc < rel_cyc);
    end
    // Transmitter: active for 40 clocks, then done for 2 clocks; not reset by rst_n.
    if (o_Tx_DV && !tx_busy) begin
      tx_busy = 1; tx_active = 1; tx_cnt = 0;
    end else if (tx_busy) begin
      tx_cnt++;
      if (tx_cnt == 40) begin tx_active = 0; tx_done = 1; end
      else if (tx_cnt == 42) begin
        tx_done = 0; tx_busy = 0; fall_cyc = cyc;
        if (seq_owned) begin qaf = mcnt > 0; rel_cyc = cyc + 1 + GAP; seq_owned = 0; end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic wr(logic [7:0] b);
    wr_dv = 1; wr_byte = b; step(); wr_dv = 0;
  endtask
  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (!(o_Empty && !o_Busy && !tx_busy) && n < budget) begin step(); n++; end
    chk(name, n < budget, 1);
  endtask

  initial begin
    int base, n;
    rst_n = 0; wr_dv = 0; wr_byte = 0; ovf_clr = 0; stall = 0; tx_active = 0; tx_done = 0;
    step(3);
    rst_n = 1;
    step(2);
    // Single byte: launch two edges after the write, one-cycle pulse.
    wr(8'hA5);
    chk("lat_edge1_dv", o_Tx_DV, 0);
    chk("lat_edge1_count", o_Count, 1);
    step();
    chk("lat_edge2_dv", o_Tx_DV, 1);
    chk("lat_edge2_byte", o_Tx_Byte, 8'hA5);
    step();
    chk("dv_one_cycle", o_Tx_DV, 0);
    chk("byte_held", o_Tx_Byte, 8'hA5);
    wait_idle("single_drain_timeout", 200);
    // Burst of five: count peaks at 4 since the first byte pops immediately.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("burst_peak_count", o_Count, 4);
    wait_idle("burst_drain_timeout", 400);
    // Fill with the transmitter stalled; 17th write dropped even with a clear.
    stall = 1;
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    chk("full_after_16", o_Full, 1);
    chk("count_16", o_Count, 16);
    ovf_clr = 1; wr(8'hEE); ovf_clr = 0;
    chk("ovf_set_wins", o_Overflow, 1);
    chk("count_still_16", o_Count, 16);
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("ovf_cleared", o_Overflow, 0);
    // Write at full coinciding with a pop is still dropped.
    stall = 0; wr(8'hEF);
    chk("full_pop_dv", o_Tx_DV, 1);
    chk("full_pop_ovf", o_Overflow, 1);
    chk("full_pop_count", o_Count, 15);
    wait_idle("full_drain_timeout", 1000);
    ovf_clr = 1; step(); ovf_clr = 0;
    // Write and pop together at count 3 leave the count unchanged.
    stall = 1;
    for (int i = 0; i < 3; i++) wr(8'h70 + 8'(i));
    chk("count_3", o_Count, 3);
    stall = 0; wr(8'h73);
    chk("wr_pop_dv", o_Tx_DV, 1);
    chk("wr_pop_count", o_Count, 3);
    wait_idle("cnt3_drain_timeout", 400);
    // Reset during the third of five frames.
    base = launches;
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i));
    n = 0;
    while (launches < base + 3 && n < 500) begin step(); n++; end
    chk("third_launch_timeout", n < 500, 1);
    step(10);
    rst_n = 0; #1;
    chk("async_rst_dv", o_Tx_DV, 0);
    chk("async_rst_count", o_Count, 0);
    chk("async_rst_empty", o_Empty, 1);
    chk("async_rst_busy", o_Busy, 0);
    step();
    rst_n = 1;
    wr(8'h3C);
    wait_idle("post_rst_timeout", 400);
    chk("post_rst_byte", last_byte, 8'h3C);
    // Two queued bytes exercise the relaunch delay (gap when enabled).
    wr(8'h11); wr(8'h22);
    wait_idle("gap_drain_timeout", 400);
    chk("gap_last_byte", last_byte, 8'h22);
    // Randomized traffic with occasional overflow clears.
    for (int i = 0; i < 600; i++) begin
      wr_dv = $urandom_range(0, 2) == 0;
      wr_byte = 8'($urandom);
      ovf_clr = $urandom_range(0, 15) == 0;
      step();
    end
    wr_dv = 0; ovf_clr = 0;
    wait_idle("random_drain_timeout", 2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host-side write port and holds up to DEPTH of them.
- Issues each byte to the transmitter as a one-cycle data-valid pulse.
- Tracks the transmitter's active/done handshake so no byte is issued while the transmitter is busy or in its post-stop cleanup cycle.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- GAP_CLKS, 16'd0: extra idle clocks between frames; used only when UART_TX_BUF_GAP_EN is defined.

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Wr_DV  in  1  write strobe, one byte per high cycle.
- i_Wr_Byte  in  8  byte to enqueue.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  $clog2(DEPTH+1)  current occupancy.
- o_Overflow  out  1  sticky: a write was dropped.
- i_Ovf_Clr  in  1  clears o_Overflow.
- o_Tx_DV  out  1  one-cycle launch pulse to the transmitter.
- o_Tx_Byte  out  8  byte presented with o_Tx_DV; held until the next launch.
- i_Tx_Active  in  1  transmitter active flag.
- i_Tx_Done  in  1  transmitter done flag; high for 2 consecutive cycles at end of frame.
- o_Busy  out  1  sequencer not in S_IDLE, or FIFO non-empty.

Behaviour:
- Reset (async assert, sync release):
  - o_Tx_DV=0, o_Tx_Byte=8'h00, o_Overflow=0, o_Count=0, o_Empty=1, o_Full=0, o_Busy=0.
  - Read/write pointers=0, state=S_IDLE, gap counter=0.
  - FIFO contents are not cleared; they are don't-care.
  - Reset mid-frame discards all queued bytes. The transmitter itself is not reset by this block.
- Write:
  - Byte is accepted on i_Wr_DV=1 && o_Full=0 (registered o_Full). It is stored at wr_ptr, wr_ptr increments, count increments.
  - i_Wr_DV=1 && o_Full=1: byte dropped, o_Overflow<=1. This holds even if a pop happens in the same cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Overflow flag: i_Ovf_Clr clears o_Overflow. If a clear and a new overflow occur in the same cycle, the set wins.
- Simultaneous write and pop when not full: count is unchanged, both pointers advance.
- Flags: o_Full, o_Empty and o_Count are registered and consistent with each other every cycle.
- Sequencer states:
  - S_IDLE: if !o_Empty && i_Tx_Active==0 && i_Tx_Done==0, then on the next edge o_Tx_DV<=1, o_Tx_Byte<=mem[rd_ptr], rd_ptr++, count--, go to S_WAIT_ACT. Otherwise stay.
  - S_WAIT_ACT: o_Tx_DV<=0. Go to S_WAIT_DONE when i_Tx_Active==1.
  - S_WAIT_DONE: go to S_WAIT_REL when i_Tx_Done==1.
  - S_WAIT_REL: when i_Tx_Done==0, go to S_GAP if the feature is enabled and GAP_CLKS≠0, else to S_IDLE.
  - S_GAP: count GAP_CLKS clocks, then go to S_IDLE.
  - Any illegal state goes to S_IDLE with o_Tx_DV=0.
- Timing:
  - o_Tx_DV is high for exactly 1 cycle per byte, and never while i_Tx_Active=1.
  - Latency from the first write into an empty FIFO (transmitter idle) to o_Tx_DV high is 2 clocks: the write edge, then the launch edge.
  - Back-to-back frames with no gap: next o_Tx_DV rises 2 clocks after i_Tx_Done falls.
  - A byte written while the FIFO is empty and a frame is in flight waits for the handshake. It is never launched early.
  - Bytes are issued in write order; none are lost or duplicated unless they were dropped on a full write.

Optional Feature:
- Macro: UART_TX_BUF_GAP_EN.
- Defined: S_GAP exists, with a 16-bit counter that inserts GAP_CLKS idle clocks after each frame (extra stop time for slow receivers). GAP_CLKS=0 skips S_GAP.
- Undefined: no S_GAP state and no counter logic; S_WAIT_REL goes straight to S_IDLE. GAP_CLKS is ignored.

Test Plan:
- Bench setup: attach the transmitter with CLKS_PER_BIT=4 (frame = 40 clocks).
- Single byte: write 8'hA5 once → o_Tx_DV pulses 1 cycle with o_Tx_Byte=8'hA5, 2 clocks after the write. Serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first, stop bit 1). o_Busy falls after i_Tx_Done falls.
- Burst: write 8'h01..8'h05 on consecutive cycles → five frames in order, each o_Tx_DV only after the previous i_Tx_Done falls, no lost bytes. o_Count peaks at 4 (first byte already popped).
- Full/overflow: with DEPTH=16, stall the transmitter by holding i_Tx_Active=1, write 17 bytes → o_Full=1 after the 16th. The 17th is dropped and o_Overflow=1. i_Ovf_Clr for 1 cycle → o_Overflow=0.
- Simultaneous events: at full, i_Wr_DV coincides with a pop → write dropped, o_Overflow=1, o_Count=15. At count 3, write+pop together → o_Count stays 3.
- Reset mid-frame: assert i_Rst_n=0 for 1 cycle during the 3rd of 5 frames → o_Tx_DV=0, o_Count=0, o_Empty=1, state S_IDLE immediately. Subsequent write 8'h3C transmits correctly after the transmitter finishes its frame.
- Gap (macro defined, GAP_CLKS=10): two queued bytes → second o_Tx_DV rises exactly 12 clocks after i_Tx_Done falls (10 gap + 2).
